// File: rtl/munoc_axi_slave_outstanding_limiter_if.sv
// AXI bundle (AW/W/B/AR/R) between the slave NI, the outstanding limiter and the slave.
`ifndef DEFAULT_BW_AXI_TID
`define DEFAULT_BW_AXI_TID 4
`endif

interface munoc_axi_slave_outstanding_limiter_if #(
  parameter int unsigned BW_PLATFORM_ADDR = 32,
  parameter int unsigned BW_NODE_DATA     = 32,
  parameter int unsigned BW_AXI_SLAVE_TID = `DEFAULT_BW_AXI_TID
);
  localparam int unsigned BW_STRB = BW_NODE_DATA / 8;

  logic [BW_AXI_SLAVE_TID-1:0] awid;
  logic [BW_PLATFORM_ADDR-1:0] awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid;
  logic                        awready;

  logic [BW_AXI_SLAVE_TID-1:0] wid;
  logic [BW_NODE_DATA-1:0]     wdata;
  logic [BW_STRB-1:0]          wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;

  logic [BW_AXI_SLAVE_TID-1:0] bid;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;

  logic [BW_AXI_SLAVE_TID-1:0] arid;
  logic [BW_PLATFORM_ADDR-1:0] araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;

  logic [BW_AXI_SLAVE_TID-1:0] rid;
  logic [BW_NODE_DATA-1:0]     rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;

  // Issuer of requests (NI side toward the limiter, limiter toward the slave)
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  // Receiver of requests
  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/munoc_axi_slave_outstanding_limiter.sv
// Outstanding AW/AR limiter with drain handshake between the AXI slave NI (rx) and
// the slave (sx). Bus widths come from the interface instances' parameters.
module munoc_axi_slave_outstanding_limiter #(
  parameter int unsigned MAX_WR_OUTSTANDING = 4,
  parameter int unsigned MAX_RD_OUTSTANDING = 4
) (
  input  logic       clk,
  input  logic       rstnn,
  input  logic       drain_req,
  output logic       drain_done,
  output logic [7:0] wr_outstanding,
  output logic [7:0] rd_outstanding,
  munoc_axi_slave_outstanding_limiter_if.slave  rx,
  munoc_axi_slave_outstanding_limiter_if.master sx
);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, DRAINING, DRAINED} drain_state_e;

  drain_state_e     state, state_next;
  logic             aw_open_c, ar_open_c;
  logic             aw_fire, b_fire, ar_fire, r_fire;
  logic             wr_underflow, rd_underflow;
  logic [CNT_W-1:0] wr_cnt_next, rd_cnt_next;

  // Issue windows: registered counts and drain_req only, never the gated valid
  assign aw_open_c = (wr_outstanding < CNT_W'(MAX_WR_OUTSTANDING)) && !drain_req;
  assign ar_open_c = (rd_outstanding < CNT_W'(MAX_RD_OUTSTANDING)) && !drain_req;

  // AW: gated handshake, payload straight through
  assign sx.awid    = rx.awid;
  assign sx.awaddr  = rx.awaddr;
  assign sx.awlen   = rx.awlen;
  assign sx.awsize  = rx.awsize;
  assign sx.awburst = rx.awburst;
  assign sx.awvalid = rx.awvalid & aw_open_c;
  assign rx.awready = sx.awready & aw_open_c;

  // AR: gated handshake, payload straight through
  assign sx.arid    = rx.arid;
  assign sx.araddr  = rx.araddr;
  assign sx.arlen   = rx.arlen;
  assign sx.arsize  = rx.arsize;
  assign sx.arburst = rx.arburst;
  assign sx.arvalid = rx.arvalid & ar_open_c;
  assign rx.arready = sx.arready & ar_open_c;

  // W, B, R: ungated pass-through (W may lead AW)
  assign sx.wid    = rx.wid;
  assign sx.wdata  = rx.wdata;
  assign sx.wstrb  = rx.wstrb;
  assign sx.wlast  = rx.wlast;
  assign sx.wvalid = rx.wvalid;
  assign rx.wready = sx.wready;

  assign rx.bid    = sx.bid;
  assign rx.bresp  = sx.bresp;
  assign rx.bvalid = sx.bvalid;
  assign sx.bready = rx.bready;

  assign rx.rid    = sx.rid;
  assign rx.rdata  = sx.rdata;
  assign rx.rresp  = sx.rresp;
  assign rx.rlast  = sx.rlast;
  assign rx.rvalid = sx.rvalid;
  assign sx.rready = rx.rready;

  assign aw_fire = sx.awvalid & sx.awready;
  assign b_fire  = sx.bvalid  & sx.bready;
  assign ar_fire = sx.arvalid & sx.arready;
  assign r_fire  = sx.rvalid  & sx.rready & sx.rlast;

  // Next counts; a lone retire at zero is a protocol error and saturates
  always_comb begin
    wr_cnt_next  = wr_outstanding;
    rd_cnt_next  = rd_outstanding;
    wr_underflow = 1'b0;
    rd_underflow = 1'b0;
    case ({aw_fire, b_fire})
      2'b10:   wr_cnt_next = wr_outstanding + CNT_W'(1);
      2'b01: begin
        if (wr_outstanding == '0) wr_underflow = 1'b1;
        else                      wr_cnt_next  = wr_outstanding - CNT_W'(1);
      end
      default: wr_cnt_next = wr_outstanding;
    endcase
    case ({ar_fire, r_fire})
      2'b10:   rd_cnt_next = rd_outstanding + CNT_W'(1);
      2'b01: begin
        if (rd_outstanding == '0) rd_underflow = 1'b1;
        else                      rd_cnt_next  = rd_outstanding - CNT_W'(1);
      end
      default: rd_cnt_next = rd_outstanding;
    endcase
  end

  // Drain FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (drain_req) state_next = DRAINING;
      DRAINING: begin
        if (!drain_req)
          state_next = IDLE;
        else if (wr_outstanding == '0 && rd_outstanding == '0)
          state_next = DRAINED;
      end
      DRAINED:  if (!drain_req) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State, counters and drain_done registers
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state          <= IDLE;
      wr_outstanding <= '0;
      rd_outstanding <= '0;
      drain_done     <= 1'b0;
    end else begin
      state          <= state_next;
      wr_outstanding <= wr_cnt_next;
      rd_outstanding <= rd_cnt_next;
      drain_done     <= (state_next == DRAINED);
    end
  end

`ifndef SYNTHESIS
  // Simulation warning on retire without a matching issue
  always @(posedge clk) begin
    if (rstnn && wr_underflow)
      $display("%m WARNING: B response with zero writes outstanding at %0t", $time);
    if (rstnn && rd_underflow)
      $display("%m WARNING: final R beat with zero reads outstanding at %0t", $time);
  end
`endif
endmodule

// File: tb/tb_munoc_axi_slave_outstanding_limiter.sv
// Directed bench for the outstanding limiter: MAX_WR=2, MAX_RD=1.
module tb_munoc_axi_slave_outstanding_limiter;
  logic       clk;
  logic       rstnn;
  logic       drain_req;
  logic       drain_done;
  logic [7:0] wr_outstanding;
  logic [7:0] rd_outstanding;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  munoc_axi_slave_outstanding_limiter_if #(.BW_PLATFORM_ADDR(32), .BW_NODE_DATA(32), .BW_AXI_SLAVE_TID(4)) rx_if ();
  munoc_axi_slave_outstanding_limiter_if #(.BW_PLATFORM_ADDR(32), .BW_NODE_DATA(32), .BW_AXI_SLAVE_TID(4)) sx_if ();

  munoc_axi_slave_outstanding_limiter #(
    .MAX_WR_OUTSTANDING(2),
    .MAX_RD_OUTSTANDING(1)
  ) dut (
    .clk            (clk),
    .rstnn          (rstnn),
    .drain_req      (drain_req),
    .drain_done     (drain_done),
    .wr_outstanding (wr_outstanding),
    .rd_outstanding (rd_outstanding),
    .rx             (rx_if.slave),
    .sx             (sx_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {drain_req, awvalid, sx awready, sx bvalid, arvalid, sx arready, sx rvalid, sx rlast}
  // eo  = {sx awvalid, rx awready, sx arvalid, rx arready}
  typedef struct packed {
    logic [7:0] in;
    logic [3:0] eo;
    logic [7:0] e_wr;
    logic [7:0] e_rd;
    logic       e_dd;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [7:0] in, input logic [3:0] eo,
                              input int wr, input int rd, input int dd);
    vec_t v;
    v.in   = in;
    v.eo   = eo;
    v.e_wr = 8'(wr);
    v.e_rd = 8'(rd);
    v.e_dd = 1'(dd);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic apply(input logic [7:0] in);
    drain_req        = in[7];
    rx_if.awvalid    = in[6];
    sx_if.awready    = in[5];
    sx_if.bvalid     = in[4];
    rx_if.arvalid    = in[3];
    sx_if.arready    = in[2];
    sx_if.rvalid     = in[1];
    sx_if.rlast      = in[0];
  endtask

  initial begin
    // Test 1: write limit; Test 3: simultaneous AW/B; Test 5: spurious B
    vecs[0]  = mk(8'b0110_0000, 4'b1100, 0, 0, 0);
    vecs[1]  = mk(8'b0110_0000, 4'b1100, 1, 0, 0);
    vecs[2]  = mk(8'b0110_0000, 4'b0000, 2, 0, 0);
    vecs[3]  = mk(8'b0111_0000, 4'b0000, 2, 0, 0);
    vecs[4]  = mk(8'b0110_0000, 4'b1100, 1, 0, 0);
    vecs[5]  = mk(8'b0001_0000, 4'b0000, 2, 0, 0);
    vecs[6]  = mk(8'b0111_0000, 4'b1100, 1, 0, 0);
    vecs[7]  = mk(8'b0011_0000, 4'b0100, 1, 0, 0);
    vecs[8]  = mk(8'b0000_0000, 4'b0000, 0, 0, 0);
    vecs[9]  = mk(8'b0001_0000, 4'b0000, 0, 0, 0);
    vecs[10] = mk(8'b0000_0000, 4'b0000, 0, 0, 0);
    // Test 2: 4-beat read with MAX_RD=1
    vecs[11] = mk(8'b0000_1100, 4'b0011, 0, 0, 0);
    vecs[12] = mk(8'b0000_1110, 4'b0000, 0, 1, 0);
    vecs[13] = mk(8'b0000_1110, 4'b0000, 0, 1, 0);
    vecs[14] = mk(8'b0000_1110, 4'b0000, 0, 1, 0);
    vecs[15] = mk(8'b0000_1111, 4'b0000, 0, 1, 0);
    vecs[16] = mk(8'b0000_1100, 4'b0011, 0, 0, 0);
    vecs[17] = mk(8'b0000_0011, 4'b0000, 0, 1, 0);
    vecs[18] = mk(8'b0000_0000, 4'b0000, 0, 0, 0);
    // Test 4: drain with one write outstanding
    vecs[19] = mk(8'b0110_0000, 4'b1100, 0, 0, 0);
    vecs[20] = mk(8'b1000_1100, 4'b0000, 1, 0, 0);
    vecs[21] = mk(8'b1001_1100, 4'b0000, 1, 0, 0);
    vecs[22] = mk(8'b1000_1100, 4'b0000, 0, 0, 0);
    vecs[23] = mk(8'b1000_1100, 4'b0000, 0, 0, 1);
    vecs[24] = mk(8'b0000_1100, 4'b0011, 0, 0, 1);
    vecs[25] = mk(8'b0000_0000, 4'b0000, 0, 1, 0);
    vecs[26] = mk(8'b0000_0011, 4'b0000, 0, 1, 0);
    // Drain with counts already zero: done two edges later
    vecs[27] = mk(8'b1000_0000, 4'b0000, 0, 0, 0);
    vecs[28] = mk(8'b1000_0000, 4'b0000, 0, 0, 0);
    vecs[29] = mk(8'b1000_0000, 4'b0000, 0, 0, 1);
    vecs[30] = mk(8'b0000_0000, 4'b0000, 0, 0, 1);
    vecs[31] = mk(8'b0000_0000, 4'b0000, 0, 0, 0);

    rstnn = 1'b0;
    apply(8'h00);
    rx_if.awid = 4'h5;  rx_if.awaddr = 32'hCAFE_0010; rx_if.awlen = 8'd0;
    rx_if.awsize = 3'd2; rx_if.awburst = 2'd1;
    rx_if.arid = 4'h6;  rx_if.araddr = 32'h0000_2000; rx_if.arlen = 8'd3;
    rx_if.arsize = 3'd2; rx_if.arburst = 2'd1;
    rx_if.wid = 4'h5; rx_if.wdata = 32'hDEAD_BEEF; rx_if.wstrb = 4'hF;
    rx_if.wlast = 1'b1; rx_if.wvalid = 1'b1;
    sx_if.wready = 1'b1;
    rx_if.bready = 1'b1; rx_if.rready = 1'b1;
    sx_if.bid = 4'h3; sx_if.bresp = 2'b00;
    sx_if.rid = 4'h6; sx_if.rdata = 32'h0BAD_F00D; sx_if.rresp = 2'b00;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset wr_outstanding", 32'(wr_outstanding), 32'd0);
    chk("reset rd_outstanding", 32'(rd_outstanding), 32'd0);
    chk("reset drain_done", 32'(drain_done), 32'd0);
    chk("reset sx awvalid idle", 32'(sx_if.awvalid), 32'd0);
    @(negedge clk);
    rstnn = 1'b1;

    // Pass-through payloads
    #1;
    chk("pass awaddr", sx_if.awaddr, 32'hCAFE_0010);
    chk("pass awid", 32'(sx_if.awid), 32'h5);
    chk("pass arlen", 32'(sx_if.arlen), 32'd3);
    chk("pass wdata", sx_if.wdata, 32'hDEAD_BEEF);
    chk("pass wvalid", 32'(sx_if.wvalid), 32'd1);
    chk("pass wready", 32'(rx_if.wready), 32'd1);
    chk("pass bid", 32'(rx_if.bid), 32'h3);
    chk("pass rdata", rx_if.rdata, 32'h0BAD_F00D);
    chk("pass bready", 32'(sx_if.bready), 32'd1);

    // Table-driven vectors: apply after negedge, check before next posedge
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply(vecs[i].in);
      #1;
      chk($sformatf("v%0d sx_awvalid", i), 32'(sx_if.awvalid), 32'(vecs[i].eo[3]));
      chk($sformatf("v%0d rx_awready", i), 32'(rx_if.awready), 32'(vecs[i].eo[2]));
      chk($sformatf("v%0d sx_arvalid", i), 32'(sx_if.arvalid), 32'(vecs[i].eo[1]));
      chk($sformatf("v%0d rx_arready", i), 32'(rx_if.arready), 32'(vecs[i].eo[0]));
      chk($sformatf("v%0d wr_outstanding", i), 32'(wr_outstanding), 32'(vecs[i].e_wr));
      chk($sformatf("v%0d rd_outstanding", i), 32'(rd_outstanding), 32'(vecs[i].e_rd));
      chk($sformatf("v%0d drain_done", i), 32'(drain_done), 32'(vecs[i].e_dd));
    end

    // Test 6: async reset while DRAINING with wr=2, rd=1
    @(negedge clk); apply(8'b0110_1100);
    @(negedge clk); apply(8'b0110_0000);
    @(negedge clk); apply(8'b1000_0000);
    @(negedge clk);
    #1;
    chk("pre-reset wr_outstanding", 32'(wr_outstanding), 32'd2);
    chk("pre-reset rd_outstanding", 32'(rd_outstanding), 32'd1);
    chk("pre-reset drain_done", 32'(drain_done), 32'd0);
    #1;
    rstnn = 1'b0;
    #1;
    chk("async reset wr_outstanding", 32'(wr_outstanding), 32'd0);
    chk("async reset rd_outstanding", 32'(rd_outstanding), 32'd0);
    chk("async reset drain_done", 32'(drain_done), 32'd0);
    @(negedge clk);
    rstnn = 1'b1;
    apply(8'b1000_0000);
    // From IDLE a held drain_req needs two edges; a stale DRAINING would need one
    @(negedge clk);
    #1;
    chk("post-reset drain_done after 1 edge", 32'(drain_done), 32'd0);
    @(negedge clk);
    #1;
    chk("post-reset drain_done after 2 edges", 32'(drain_done), 32'd1);
    @(negedge clk);
    apply(8'b0110_0000);
    #1;
    chk("post-drain aw reopens", 32'(sx_if.awvalid), 32'd1);
    @(negedge clk);
    apply(8'h00);
    #1;
    chk("post-drain wr_outstanding", 32'(wr_outstanding), 32'd1);
    chk("post-drain drain_done low", 32'(drain_done), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
